fft_sdf_stage: RTL
==================

# fft_sdf_stage

Parametrised radix-2 single-path delay-feedback (SDF) FFT stage, the successor to the fixed 4-point datapath. Generalises the feedback delay depth and data/twiddle widths. Generates its own mux/demux sequencing from an internal sample counter instead of external `sel` lines, and adds a valid handshake, stall-on-bubble and saturating fixed-point arithmetic. Stages are cascaded (DEPTH = N/2, N/4, …, 1-equivalent) to build an N-point real-valued pipelined FFT. Twiddles come from an external ROM addressed by `tw_idx`.

## Interface
- `W`, 8: data width, two's complement.
- `DEPTH`, 2: feedback delay length in samples. Power of 2, ≥ 2. Frame length is 2·DEPTH.
- `TW_W`, 8: twiddle width, two's complement.
- `TW_FRAC`, 6: twiddle fractional bits; 1.0 = 2^TW_FRAC.

Ports:
- `clk` in 1: single clock, rising edge.
- `clear` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_data` is accepted this cycle.
- `in_data` in W: input sample.
- `tw` in TW_W: twiddle for the current `tw_idx`. Sampled in the same cycle.
- `tw_idx` out log2(DEPTH): twiddle ROM address. Combinational from the counter.
- `out_valid` out 1: `out_data` is valid.
- `out_data` out W: stage output, registered.

## Operation
- `cnt` (log2(2·DEPTH) bits) increments on every accepted sample and wraps from 2·DEPTH−1 to 0. `phase` = MSB of `cnt`. `tw_idx` = `cnt` low bits.
- The delay line (DEPTH × W) shifts only on accepted samples. `d_out` is its oldest entry.
- **Phase 0 (fill):**
  - `in_data` enters the delay line.
  - Output = sat_W((`d_out` · `tw`) >>> TW_FRAC). `d_out` is the previous frame's difference.
  - Full product width is W+TW_W, arithmetic shift, then saturate.
- **Phase 1 (butterfly):**
  - Sum = `d_out` + `in_data`, computed at W+1 bits, goes to the output.
  - Diff = `d_out` − `in_data` goes into the delay line.
  - Both are reduced to W bits per the Configuration rule.
- `primed` flag: clears on reset and sets on the first phase-1 sample. Phase-0 outputs are valid only when `primed`=1. The very first DEPTH samples after reset produce no output.
- Bubbles (`in_valid`=0): counter, delay line and `primed` hold; `out_valid` goes to 0 the next cycle.
- The last frame's differences emerge only when the next frame's phase 0 arrives. There is no self-flush.
- Reset mid-frame: `cnt`, delay line, `primed`, `out_valid` and `out_data` all go to 0 immediately. The partial frame is discarded.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `tw_idx`=0.
- Latency: a sample accepted in cycle t produces its output (sum, or twiddled diff) at t+1.
- `out_valid`(t+1) = `in_valid`(t) & (`phase`(t) | `primed`(t)).
- `tw` must be stable in the cycle `in_valid`=1 during phase 0. The external ROM is combinational, or is pre-registered using `tw_idx` of the next accepted sample.
- Throughput: one sample per cycle, no backpressure input.

## Configuration
- `FFT_SDF_SCALE_EN` defined:
  - Sum and diff are arithmetic-shifted right by 1 (truncate toward −∞) from W+1 to W bits.
  - Suits a cascade with per-stage 1/2 scaling.
- `FFT_SDF_SCALE_EN` undefined: sum and diff are saturated to [−2^(W−1), 2^(W−1)−1].
- The twiddle product is always saturated, regardless of the macro.

## Structure
- Shared package `fft_pkg` holds:
  - the saturate function (generic input width to W);
  - the clog2 helper;
  - the twiddle-one constant (1 << TW_FRAC).
- Sub-module `sdf_delay_line`: DEPTH × W shift register with enable and async active-low `clear`.
- Top level holds the counter, phase logic, butterfly, multiplier and output register.

## Test plan
All cases use W=8, DEPTH=2, TW_FRAC=6, macro off unless stated.
- Reset: assert `clear`=0 mid-stream → `out_valid`=0 and `out_data`=0 immediately. After release, the first 2 samples give no `out_valid`.
- Frame [1,2,3,4] then [0,0,…], `tw`=64:
  - the 3rd and 4th inputs give outputs 4 and 6 one cycle later;
  - the next frame's first two inputs give −2 and −2.
- Same stimulus with `tw`=−64 → the difference outputs are +2 and +2. With `tw`=32 → −1 and −1.
- Frame [100,100,100,100], macro off → sums saturate to 127 and 127. Macro on → 100 and 100, diffs 0.
- Random `in_valid` gaps inserted into the frame-[1,2,3,4] stream → identical `out_data` sequence, `out_valid` low one cycle after each gap, and `tw_idx` holding during gaps.
- 1000 random frames vs. golden model (macro on and off) → bit-exact match, with `tw_idx` sequencing 0,1 in each phase 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared helpers for the SDF FFT stages: saturation, clog2, twiddle unity and phase encoding.
package fft_pkg;

   typedef enum logic {
      PH_FILL = 1'b0,
      PH_BFLY = 1'b1
   } phase_t;

   localparam int unsigned SAT_IN_W = 64;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
         res = res + 1;
      end
      return res;
   endfunction

   // Clamps a sign-extended value of any narrower width into the signed w-bit range.
   function automatic logic signed [SAT_IN_W-1:0] saturate(
      input logic signed [SAT_IN_W-1:0] x,
      input int unsigned                w
   );
      logic signed [SAT_IN_W-1:0] hi;
      logic signed [SAT_IN_W-1:0] lo;
      hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 32'd1));
      if (x > hi) begin
         return hi;
      end else if (x < lo) begin
         return lo;
      end
      return x;
   endfunction

   function automatic int unsigned twiddle_one(input int unsigned frac);
      return 32'd1 << frac;
   endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// DEPTH x W shift register with enable; q is the oldest entry. Async active-low clear.
module sdf_delay_line #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (en) begin
         mem[0] <= d;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign q = mem[DEPTH-1];

endmodule

// File: rtl/fft_sdf_stage.sv
// Radix-2 single-path delay-feedback FFT stage with self-sequencing counter and valid handshake.
// Build option: FFT_SDF_SCALE_EN selects halving of butterfly results instead of saturation.
module fft_sdf_stage
   import fft_pkg::*;
#(
   parameter int unsigned W       = 8,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned TW_W    = 8,
   parameter int unsigned TW_FRAC = 6
) (
   input  logic                     clk,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic [W-1:0]             in_data,
   input  logic [TW_W-1:0]          tw,
   output logic [clog2(DEPTH)-1:0]  tw_idx,
   output logic                     out_valid,
   output logic [W-1:0]             out_data
);

   localparam int unsigned CW = clog2(2 * DEPTH);
   localparam int unsigned IW = clog2(DEPTH);
   localparam int unsigned PW = W + TW_W;

   logic [CW-1:0]              cnt;
   logic                       primed;
   phase_t                     phase;
   logic [W-1:0]               d_out;
   logic [W-1:0]               dl_in;

   logic signed [W:0]          sum_w;
   logic signed [W:0]          diff_w;
   logic signed [W-1:0]        sum_r;
   logic signed [W-1:0]        diff_r;
   logic signed [PW-1:0]       prod;
   logic signed [PW-1:0]       prod_sh;
   logic signed [W-1:0]        twid;
   logic signed [SAT_IN_W-1:0] sat_sum;
   logic signed [SAT_IN_W-1:0] sat_diff;
   logic signed [SAT_IN_W-1:0] sat_prod;
   logic [W-1:0]               out_next;

   assign phase  = phase_t'(cnt[CW-1]);
   assign tw_idx = cnt[IW-1:0];

   sdf_delay_line #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_delay (
      .clk   (clk),
      .clear (clear),
      .en    (in_valid),
      .d     (dl_in),
      .q     (d_out)
   );

   always_comb begin
      sum_w    = $signed({d_out[W-1], d_out}) + $signed({in_data[W-1], in_data});
      diff_w   = $signed({d_out[W-1], d_out}) - $signed({in_data[W-1], in_data});
      sat_sum  = saturate(SAT_IN_W'(sum_w), W);
      sat_diff = saturate(SAT_IN_W'(diff_w), W);
`ifdef FFT_SDF_SCALE_EN
      sum_r    = sum_w[W:1];
      diff_r   = diff_w[W:1];
`else
      sum_r    = sat_sum[W-1:0];
      diff_r   = sat_diff[W-1:0];
`endif
      prod     = PW'($signed(d_out)) * PW'($signed(tw));
      prod_sh  = prod >>> TW_FRAC;
      sat_prod = saturate(SAT_IN_W'(prod_sh), W);
      twid     = sat_prod[W-1:0];

      dl_in    = in_data;
      out_next = twid;
      if (phase == PH_BFLY) begin
         dl_in    = diff_r;
         out_next = sum_r;
      end
   end

   // primed is sampled before its own update, so the first frame's fill emits nothing.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         cnt       <= '0;
         primed    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= in_valid & ((phase == PH_BFLY) | primed);
         if (in_valid) begin
            cnt <= cnt + CW'(1);
            if (phase == PH_BFLY) begin
               primed <= 1'b1;
            end
            if ((phase == PH_BFLY) || primed) begin
               out_data <= out_next;
            end
         end
      end
   end

endmodule
